// File: rtl/systolic_array_ctrl_if.sv
// Handshake and array-facing bus of the systolic array tile sequencer.
// master = tile buffer / DMA side, slave = the sequencer itself.
interface systolic_array_ctrl_if #(
  parameter int SIZE       = 16,
  parameter int DATA_WIDTH = 8,
  parameter int K_WIDTH    = 16
);
  logic                       start;
  logic [K_WIDTH-1:0]         k_len;
  logic                       busy;
  logic                       in_valid;
  logic                       in_ready;
  logic [SIZE*DATA_WIDTH-1:0] a_col;
  logic [SIZE*DATA_WIDTH-1:0] b_row;
  logic                       sa_accum_reset;
  logic [SIZE*DATA_WIDTH-1:0] sa_west_inputs;
  logic [SIZE*DATA_WIDTH-1:0] sa_north_inputs;
  logic                       result_valid;
  logic                       result_ack;

  modport master (
    output start, k_len, in_valid, a_col, b_row, result_ack,
    input  busy, in_ready, sa_accum_reset, sa_west_inputs, sa_north_inputs, result_valid
  );

  modport slave (
    input  start, k_len, in_valid, a_col, b_row, result_ack,
    output busy, in_ready, sa_accum_reset, sa_west_inputs, sa_north_inputs, result_valid
  );
endinterface

// File: rtl/systolic_array_ctrl.sv
// Sequencer for the SIZE x SIZE systolic array: clears accumulators, skews the A/B
// beat stream onto the array edges, drains the pipeline and flags stable results.
// Optional performance counters are enabled with `define SA_CTRL_PERF_EN.
module systolic_array_ctrl #(
  parameter int SIZE       = 16,
  parameter int DATA_WIDTH = 8,
  parameter int K_WIDTH    = 16,
  parameter int PE_LAT     = 1
) (
  input logic                  clk,
  input logic                  rst,
  systolic_array_ctrl_if.slave bus
`ifdef SA_CTRL_PERF_EN
  ,
  output logic [31:0]          perf_stall_cnt,
  output logic [31:0]          perf_tile_cyc
`endif
);

  localparam int VEC       = SIZE * DATA_WIDTH;
  localparam int DRAIN_CYC = 2 * SIZE - 1 + PE_LAT;
  localparam int CW        = $clog2(DRAIN_CYC + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_e;

  state_e             state_q, state_d;
  logic [K_WIDTH-1:0] k_q, k_d;
  logic [K_WIDTH-1:0] beat_q, beat_d;
  logic [CW-1:0]      drain_q, drain_d;
  logic [VEC-1:0]     stage_a_q, stage_a_d;
  logic [VEC-1:0]     stage_b_q, stage_b_d;
  logic               accept;

  assign accept = (state_q == FEED) && bus.in_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      beat_q    <= '0;
      drain_q   <= '0;
      stage_a_q <= '0;
      stage_b_q <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      beat_q    <= beat_d;
      drain_q   <= drain_d;
      stage_a_q <= stage_a_d;
      stage_b_q <= stage_b_d;
    end
  end

  // Comparing against K-1 instead of counting to K keeps K = 2^K_WIDTH-1 wrap-free.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    beat_d    = beat_q;
    drain_d   = drain_q;
    stage_a_d = accept ? bus.a_col : '0;
    stage_b_d = accept ? bus.b_row : '0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          k_d     = bus.k_len;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        beat_d  = '0;
        state_d = (k_q == '0) ? DONE : FEED;
      end
      FEED: begin
        if (accept) begin
          if (beat_q == k_q - K_WIDTH'(1)) begin
            drain_d = '0;
            state_d = DRAIN;
          end else begin
            beat_d = beat_q + K_WIDTH'(1);
          end
        end
      end
      DRAIN: begin
        if (drain_q == CW'(DRAIN_CYC)) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q + CW'(1);
        end
      end
      DONE: begin
        if (bus.result_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy           = (state_q != IDLE);
  assign bus.in_ready       = (state_q == FEED);
  assign bus.sa_accum_reset = (state_q == CLEAR);
  assign bus.result_valid   = (state_q == DONE);

  // Lane i sits behind i+1 registers after the stage register, forming the diagonal.
  for (genvar i = 0; i < SIZE; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] a_pipe_q [0:i];
    logic [DATA_WIDTH-1:0] a_pipe_d [0:i];
    logic [DATA_WIDTH-1:0] b_pipe_q [0:i];
    logic [DATA_WIDTH-1:0] b_pipe_d [0:i];

    always_comb begin
      a_pipe_d[0] = stage_a_q[i*DATA_WIDTH +: DATA_WIDTH];
      b_pipe_d[0] = stage_b_q[i*DATA_WIDTH +: DATA_WIDTH];
      for (int j = 1; j <= i; j++) begin
        a_pipe_d[j] = a_pipe_q[j-1];
        b_pipe_d[j] = b_pipe_q[j-1];
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int j = 0; j <= i; j++) begin
          a_pipe_q[j] <= '0;
          b_pipe_q[j] <= '0;
        end
      end else begin
        a_pipe_q <= a_pipe_d;
        b_pipe_q <= b_pipe_d;
      end
    end

    assign bus.sa_west_inputs[i*DATA_WIDTH +: DATA_WIDTH]  = a_pipe_q[i];
    assign bus.sa_north_inputs[i*DATA_WIDTH +: DATA_WIDTH] = b_pipe_q[i];
  end

`ifdef SA_CTRL_PERF_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] tile_q, tile_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      tile_q  <= '0;
    end else begin
      stall_q <= stall_d;
      tile_q  <= tile_d;
    end
  end

  // Tile time covers CLEAR, FEED and DRAIN; both counters freeze in DONE/IDLE.
  always_comb begin
    stall_d = stall_q;
    tile_d  = tile_q;
    if (state_q == IDLE && bus.start) begin
      stall_d = '0;
      tile_d  = '0;
    end else begin
      if (state_q == FEED && !bus.in_valid && stall_q != '1) begin
        stall_d = stall_q + 32'd1;
      end
      if ((state_q == CLEAR || state_q == FEED || state_q == DRAIN) && tile_q != '1) begin
        tile_d = tile_q + 32'd1;
      end
    end
  end

  assign perf_stall_cnt = stall_q;
  assign perf_tile_cyc  = tile_q;
`endif

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Self-checking bench for systolic_array_ctrl: spec-level sequencer model plus a
// behavioural 16x16 int8 array fed by the DUT outputs, checked against plain matmul.
module tb_systolic_array_ctrl;

  localparam int SIZE    = 16;
  localparam int DW      = 8;
  localparam int KW      = 16;
  localparam int VEC     = SIZE * DW;
  localparam int MAXK    = 16;
  localparam int LAT_END = 33;

  localparam int P_IDLE  = 0;
  localparam int P_CLEAR = 1;
  localparam int P_FEED  = 2;
  localparam int P_DRAIN = 3;
  localparam int P_DONE  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  systolic_array_ctrl_if #(.SIZE(SIZE), .DATA_WIDTH(DW), .K_WIDTH(KW)) bus ();

`ifdef SA_CTRL_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_tile_cyc;
`endif

  systolic_array_ctrl #(.SIZE(SIZE), .DATA_WIDTH(DW), .K_WIDTH(KW), .PE_LAT(1)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus)
`ifdef SA_CTRL_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_tile_cyc  (perf_tile_cyc)
`endif
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [VEC-1:0] act, input logic [VEC-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sequencer model: phase, beats still owed, drain edges remaining, beat history.
  int             m_phase = P_IDLE;
  int             m_k     = 0;
  int             m_left  = 0;
  int             m_drain = 0;
  logic [VEC-1:0] hist_a [0:SIZE];
  logic [VEC-1:0] hist_b [0:SIZE];
  logic           m_acc;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase <= P_IDLE;
      m_k     <= 0;
      m_left  <= 0;
      m_drain <= 0;
      for (int j = 0; j <= SIZE; j++) begin
        hist_a[j] <= '0;
        hist_b[j] <= '0;
      end
    end else begin
      m_acc = (m_phase == P_FEED) && bus.in_valid;
      for (int j = SIZE; j >= 1; j--) begin
        hist_a[j] <= hist_a[j-1];
        hist_b[j] <= hist_b[j-1];
      end
      hist_a[0] <= m_acc ? bus.a_col : '0;
      hist_b[0] <= m_acc ? bus.b_row : '0;
      case (m_phase)
        P_IDLE:  if (bus.start) begin m_phase <= P_CLEAR; m_k <= int'(bus.k_len); end
        P_CLEAR: begin m_phase <= (m_k == 0) ? P_DONE : P_FEED; m_left <= m_k; end
        P_FEED:  if (m_acc) begin
                   m_left <= m_left - 1;
                   if (m_left == 1) begin m_phase <= P_DRAIN; m_drain <= LAT_END; end
                 end
        P_DRAIN: begin
                   m_drain <= m_drain - 1;
                   if (m_drain == 1) m_phase <= P_DONE;
                 end
        default: if (bus.result_ack) m_phase <= P_IDLE;
      endcase
    end
  end

  logic [VEC-1:0] exp_w, exp_n;

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < SIZE; i++) begin
        exp_w[i*DW +: DW] = hist_a[i+1][i*DW +: DW];
        exp_n[i*DW +: DW] = hist_b[i+1][i*DW +: DW];
      end
      checkOutput("busy", VEC'(bus.busy), VEC'(m_phase != P_IDLE));
      checkOutput("in_ready", VEC'(bus.in_ready), VEC'(m_phase == P_FEED));
      checkOutput("accum_reset", VEC'(bus.sa_accum_reset), VEC'(m_phase == P_CLEAR));
      checkOutput("result_valid", VEC'(bus.result_valid), VEC'(m_phase == P_DONE));
      checkOutput("west", bus.sa_west_inputs, exp_w);
      checkOutput("north", bus.sa_north_inputs, exp_n);
    end
  end

  // Behavioural array: operands hop one PE per cycle, products accumulate one cycle later.
  int pa  [SIZE][SIZE];
  int pb  [SIZE][SIZE];
  int acc [SIZE][SIZE];

  always @(posedge clk) begin
    for (int r = 0; r < SIZE; r++) begin
      for (int c = 0; c < SIZE; c++) begin
        int ia, ib;
        if (c == 0) ia = int'($signed(bus.sa_west_inputs[r*DW +: DW]));
        else        ia = pa[r][c-1];
        if (r == 0) ib = int'($signed(bus.sa_north_inputs[c*DW +: DW]));
        else        ib = pb[r-1][c];
        pa[r][c]  <= ia;
        pb[r][c]  <= ib;
        acc[r][c] <= bus.sa_accum_reset ? 0 : acc[r][c] + ia * ib;
      end
    end
  end

  byte mA   [SIZE][MAXK];
  byte mB   [MAXK][SIZE];
  int  expR [SIZE][SIZE];
  int  nz_cnt  [SIZE];
  int  nz_edge [SIZE];
  bit  saw_ready;
  int  start_edge, acc_edge, rv_edge;

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < SIZE; i++) begin
      if (bus.sa_west_inputs[i*DW +: DW] != '0) begin
        nz_cnt[i]++;
        nz_edge[i] = cyc;
      end
    end
    if (bus.in_ready) saw_ready = 1'b1;
  endtask

  // mode 0 identity/ramp, 1 all twos, 2 all ones, 3 random.
  task automatic applyStimulus(input int k, input int mode, input bit stall,
                               input bit poke_start, input int abort_after);
    int   beat, p, guard, n;
    logic rdy, vld;
    for (int r = 0; r < SIZE; r++) begin
      for (int kk = 0; kk < MAXK; kk++) begin
        case (mode)
          0: begin mA[r][kk] = (r == kk) ? 8'sd1 : 8'sd0; mB[kk][r] = byte'(kk * 16 + r); end
          1: begin mA[r][kk] = 8'sd2; mB[kk][r] = 8'sd2; end
          2: begin mA[r][kk] = 8'sd1; mB[kk][r] = 8'sd1; end
          default: begin
            mA[r][kk] = byte'($urandom_range(0, 255));
            mB[kk][r] = byte'($urandom_range(0, 255));
          end
        endcase
      end
    end
    for (int r = 0; r < SIZE; r++) begin
      for (int c = 0; c < SIZE; c++) begin
        expR[r][c] = 0;
        for (int kk = 0; kk < k; kk++) expR[r][c] += int'(mA[r][kk]) * int'(mB[kk][c]);
      end
    end
    for (int i = 0; i < SIZE; i++) begin nz_cnt[i] = 0; nz_edge[i] = -1; end
    saw_ready = 1'b0;

    bus.start = 1'b1;
    bus.k_len = KW'(k);
    tick();
    start_edge = cyc;
    bus.start = 1'b0;
    bus.k_len = '0;

    if (k > 0) begin
      n = 0;
      while (!bus.in_ready && n < 8) begin tick(); n++; end
      if (!bus.in_ready) checkOutput("ready_timeout", VEC'(0), VEC'(1));
      beat = 0; p = 0; guard = 0;
      while (beat < k && guard < 4 * k + 8) begin
        for (int r = 0; r < SIZE; r++) begin
          bus.a_col[r*DW +: DW] = mA[r][beat];
          bus.b_row[r*DW +: DW] = mB[beat][r];
        end
        bus.in_valid = !(stall && (p % 2 == 1));
        bus.start    = poke_start && (guard == 1);
        bus.k_len    = (poke_start && guard == 1) ? KW'(7) : '0;
        rdy = bus.in_ready;
        vld = bus.in_valid;
        tick();
        if (rdy && vld) begin beat++; acc_edge = cyc; end
        p++;
        guard++;
        if (abort_after >= 0 && beat == abort_after) return;
      end
      bus.in_valid = 1'b0;
      bus.start    = 1'b0;
      bus.k_len    = '0;
      bus.a_col    = '0;
      bus.b_row    = '0;
      if (beat < k) checkOutput("accept_timeout", VEC'(beat), VEC'(k));
    end

    n = 0;
    while (!bus.result_valid && n < 300) begin tick(); n++; end
    rv_edge = cyc;
    if (!bus.result_valid) checkOutput("result_valid_timeout", VEC'(0), VEC'(1));
    if (k > 0) checkOutput("result_latency", VEC'(rv_edge - acc_edge), VEC'(LAT_END));
    else       checkOutput("k0_latency", VEC'(rv_edge - start_edge), VEC'(1));
    for (int r = 0; r < SIZE; r++) begin
      for (int c = 0; c < SIZE; c++) begin
        checkOutput($sformatf("res_%0d_%0d", r, c), VEC'(acc[r][c]), VEC'(expR[r][c]));
      end
    end
    bus.result_ack = 1'b1;
    tick();
    bus.result_ack = 1'b0;
    checkOutput("rv_after_ack", VEC'(bus.result_valid), VEC'(0));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.start      = 1'b0;
    bus.k_len      = '0;
    bus.in_valid   = 1'b0;
    bus.a_col      = '0;
    bus.b_row      = '0;
    bus.result_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", VEC'(bus.busy), VEC'(0));
    checkOutput("reset_in_ready", VEC'(bus.in_ready), VEC'(0));
    checkOutput("reset_accum_reset", VEC'(bus.sa_accum_reset), VEC'(0));
    checkOutput("reset_result_valid", VEC'(bus.result_valid), VEC'(0));
    checkOutput("reset_west", bus.sa_west_inputs, '0);
    checkOutput("reset_north", bus.sa_north_inputs, '0);
    rst = 1'b1;
    repeat (3) tick();

    $display("[TB] identity tile");
    applyStimulus(16, 0, 1'b0, 1'b0, -1);
    checkOutput("identity_3_5", VEC'(acc[3][5]), VEC'(53));
    checkOutput("identity_8_0", VEC'(acc[8][0]), VEC'(-128));
    checkOutput("identity_15_15", VEC'(acc[15][15]), VEC'(-1));
`ifdef SA_CTRL_PERF_EN
    checkOutput("perf_stall_identity", VEC'(perf_stall_cnt), VEC'(0));
    checkOutput("perf_tile_identity", VEC'(perf_tile_cyc), VEC'(50));
`endif

    $display("[TB] identity tile with stalls");
    applyStimulus(16, 0, 1'b1, 1'b0, -1);
    checkOutput("stall_3_5", VEC'(acc[3][5]), VEC'(53));
`ifdef SA_CTRL_PERF_EN
    checkOutput("perf_stall_stalled", VEC'(perf_stall_cnt), VEC'(15));
    checkOutput("perf_tile_stalled", VEC'(perf_tile_cyc), VEC'(65));
`endif

    $display("[TB] skew check");
    applyStimulus(1, 2, 1'b0, 1'b0, -1);
    for (int i = 0; i < SIZE; i++) begin
      checkOutput($sformatf("skew_edge_%0d", i), VEC'(nz_edge[i] - acc_edge), VEC'(1 + i));
      checkOutput($sformatf("skew_cnt_%0d", i), VEC'(nz_cnt[i]), VEC'(1));
    end
    checkOutput("skew_0_0", VEC'(acc[0][0]), VEC'(1));
    checkOutput("skew_15_15", VEC'(acc[15][15]), VEC'(1));

    $display("[TB] accumulator clear across tiles");
    applyStimulus(4, 1, 1'b0, 1'b0, -1);
    checkOutput("tile1_0_0", VEC'(acc[0][0]), VEC'(16));
    applyStimulus(3, 2, 1'b0, 1'b1, -1);
    checkOutput("tile2_7_9", VEC'(acc[7][9]), VEC'(3));

    $display("[TB] K=0 tile");
    applyStimulus(0, 2, 1'b0, 1'b0, -1);
    checkOutput("k0_no_ready", VEC'(saw_ready), VEC'(0));
    checkOutput("k0_5_5", VEC'(acc[5][5]), VEC'(0));

    $display("[TB] reset mid-FEED");
    applyStimulus(8, 3, 1'b0, 1'b0, 5);
    bus.in_valid = 1'b0;
    bus.a_col    = '0;
    bus.b_row    = '0;
    #3;
    rst = 1'b0;
    #1;
    checkOutput("midrst_busy", VEC'(bus.busy), VEC'(0));
    checkOutput("midrst_in_ready", VEC'(bus.in_ready), VEC'(0));
    checkOutput("midrst_accum_reset", VEC'(bus.sa_accum_reset), VEC'(0));
    checkOutput("midrst_result_valid", VEC'(bus.result_valid), VEC'(0));
    checkOutput("midrst_west", bus.sa_west_inputs, '0);
    checkOutput("midrst_north", bus.sa_north_inputs, '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (40) tick();
    applyStimulus(2, 3, 1'b0, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
